// File: rtl/f1_light_timer.sv
// Tick generator for the F1 start-lights FSM: fixed-period ticks while the
// lights step on, then a pseudo-random hold of K periods before lights-out.
module f1_light_timer #(
  parameter int         WIDTH = 16,
  parameter logic [6:0] SEED  = 7'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] n,
  input  logic             cmd_seq,
  input  logic             cmd_delay,
  output logic             tick,
  output logic             time_out,
  output logic [6:0]       delay_k,
  output logic [6:0]       lfsr_out,
  output logic             delay_active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEQ,
    S_DELAY,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [6:0]       dcnt;
  logic [6:0]       lfsr;

  // x^7 + x^3 + 1; a non-zero seed can never reach the all-zero state.
  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[2]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= n;
      dcnt     <= '0;
      delay_k  <= '0;
      lfsr     <= SEED;
      tick     <= 1'b0;
      time_out <= 1'b0;
    end else begin
      lfsr     <= lfsr_next(lfsr);
      tick     <= 1'b0;
      time_out <= 1'b0;
      if (en) begin
        case (state)
          S_IDLE: begin
            cnt <= n;
            if (cmd_delay) begin
              state   <= S_DELAY;
              dcnt    <= lfsr;
              delay_k <= lfsr;
            end else if (cmd_seq) begin
              state <= S_SEQ;
            end
          end
          S_SEQ: begin
            if (cmd_delay) begin
              state   <= S_DELAY;
              dcnt    <= lfsr;
              delay_k <= lfsr;
              cnt     <= n;
            end else if (!cmd_seq) begin
              state <= S_IDLE;
              cnt   <= n;
            end else if (cnt == '0) begin
              tick <= 1'b1;
              cnt  <= n;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          S_DELAY: begin
            // FSM dropping cmd_delay early is an abort: no lights-out tick.
            if (!cmd_delay) begin
              state <= S_IDLE;
              cnt   <= n;
            end else if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              cnt <= n;
              if (dcnt == 7'd1) begin
                tick     <= 1'b1;
                time_out <= 1'b1;
                state    <= S_DONE;
              end else begin
                dcnt <= dcnt - 7'd1;
              end
            end
          end
          S_DONE: begin
            if (!cmd_delay) begin
              state <= S_IDLE;
              cnt   <= n;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign lfsr_out     = lfsr;
  assign delay_active = (state == S_DELAY);

endmodule

// File: tb/tb_f1_light_timer.sv
// Directed bench for f1_light_timer, including a closed loop with a small
// start-lights FSM model driving cmd_seq/cmd_delay from tick.
module tb_f1_light_timer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] n;
  logic        drv_seq, drv_delay;
  logic        cmd_seq, cmd_delay;
  logic        tick, time_out, delay_active;
  logic [6:0]  delay_k, lfsr_out;

  logic        loop_mode;
  logic        trig;
  logic        running;
  logic [3:0]  lights;
  logic [6:0]  m_lfsr;
  int          tick_cnt = 0;
  int          checks   = 0;
  int          fails    = 0;

  f1_light_timer #(.WIDTH(16), .SEED(7'd1)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .n            (n),
    .cmd_seq      (cmd_seq),
    .cmd_delay    (cmd_delay),
    .tick         (tick),
    .time_out     (time_out),
    .delay_k      (delay_k),
    .lfsr_out     (lfsr_out),
    .delay_active (delay_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Light FSM model: lights 0..8 advance on tick, lights-out after the delay.
  assign cmd_seq   = loop_mode ? (running && lights != 4'd8) : drv_seq;
  assign cmd_delay = loop_mode ? (running && lights == 4'd8) : drv_delay;

  always @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      lights  <= 4'd0;
    end else if (!running) begin
      if (trig) running <= 1'b1;
    end else if (tick) begin
      if (lights == 4'd8) begin
        running <= 1'b0;
        lights  <= 4'd0;
      end else begin
        lights <= lights + 4'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) m_lfsr <= 7'd1;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
  end

  always @(posedge clk) if (tick) tick_cnt <= tick_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] exp_k;
    int         kk;
    int         base;
    bit         found;

    rst = 1'b1; en = 1'b0; n = 16'd3; drv_seq = 1'b0; drv_delay = 1'b0;
    loop_mode = 1'b0; trig = 1'b0;

    // Reset state
    step();
    check("rst_tick", tick, 1'b0);
    check("rst_time_out", time_out, 1'b0);
    check("rst_delay_k", delay_k, 7'd0);
    check("rst_lfsr", lfsr_out, 7'd1);
    check("rst_delay_active", delay_active, 1'b0);

    // LFSR free-runs even with en low
    rst = 1'b0;
    step(); check("lfsr_1", lfsr_out, 7'd2);
    step(); check("lfsr_2", lfsr_out, 7'd4);
    step(); check("lfsr_3", lfsr_out, 7'd9);
    check("en_low_no_tick", tick, 1'b0);

    // Sequence mode, n=3: ticks every 4 cycles after SEQ entry
    en = 1'b1; n = 16'd3; drv_seq = 1'b1;
    step();
    check("seq_entry_tick", tick, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("seq_tick", tick, (i % 4) == 0);
      check("seq_time_out", time_out, 1'b0);
    end

    // Stall 5 cycles mid-period: next tick moves out by exactly 5
    step(); check("seq_pre_stall", tick, 1'b0);
    step(); check("seq_pre_stall", tick, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); check("seq_stall_tick", tick, 1'b0);
    end
    en = 1'b1;
    step(); check("seq_post_stall0", tick, 1'b0);
    step(); check("seq_post_stall1", tick, 1'b1);
    drv_seq = 1'b0;
    step(); check("seq_exit_tick", tick, 1'b0);
    check("lfsr_model", lfsr_out, m_lfsr);

    // Delay mode, n=2: one tick + time_out K*3 cycles after capture
    n = 16'd2; drv_delay = 1'b1;
    exp_k = m_lfsr;
    kk = int'(exp_k);
    step();
    check("dly_active", delay_active, 1'b1);
    check("dly_k", delay_k, exp_k);
    for (int i = 1; i <= 3 * kk; i++) begin
      step();
      check("dly_tick", tick, i == 3 * kk);
      check("dly_time_out", time_out, i == 3 * kk);
    end
    check("dly_active_fall", delay_active, 1'b0);
    step(); check("done_no_tick", tick, 1'b0);
    step(); check("done_no_tick", tick, 1'b0);
    drv_delay = 1'b0;
    step(); check("done_exit", delay_active, 1'b0);

    // Delay with a 5-cycle stall
    drv_delay = 1'b1;
    exp_k = m_lfsr;
    kk = int'(exp_k);
    step();
    check("dly2_k", delay_k, exp_k);
    for (int i = 1; i <= 3 * kk + 5; i++) begin
      en = (i < 3 || i > 7);
      step();
      check("dly2_tick", tick, i == 3 * kk + 5);
    end
    en = 1'b1;
    drv_delay = 1'b0;
    step(); check("dly2_exit", delay_active, 1'b0);

    // Abort: cmd_delay drops before expiry
    drv_delay = 1'b1;
    step(); check("abort_active", delay_active, 1'b1);
    step();
    drv_delay = 1'b0;
    step();
    check("abort_idle", delay_active, 1'b0);
    check("abort_no_tick", tick, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); check("abort_quiet", tick, 1'b0);
    end

    // Reset mid-delay
    drv_delay = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    step();
    check("mid_rst_active", delay_active, 1'b0);
    check("mid_rst_tick", tick, 1'b0);
    check("mid_rst_k", delay_k, 7'd0);
    check("mid_rst_lfsr", lfsr_out, 7'd1);
    rst = 1'b0; drv_delay = 1'b0;
    step();

    // Both commands high: delay wins
    drv_seq = 1'b1; drv_delay = 1'b1;
    exp_k = m_lfsr;
    step();
    check("both_active", delay_active, 1'b1);
    check("both_k", delay_k, exp_k);
    drv_seq = 1'b0; drv_delay = 1'b0;
    step(); check("both_exit", delay_active, 1'b0);

    // n=0: tick on every enabled cycle
    n = 16'd0; drv_seq = 1'b1;
    step(); check("n0_entry", tick, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); check("n0_tick", tick, 1'b1);
    end
    drv_seq = 1'b0;
    step(); step();
    check("n0_exit", tick, 1'b0);

    // Closed loop with the light FSM, n=1
    n = 16'd1; loop_mode = 1'b1;
    base = tick_cnt;
    trig = 1'b1;
    step();
    trig = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (lights == 4'd1) found = 1'b1;
      else step();
    end
    check("cl_start", found, 1'b1);
    for (int l = 1; l <= 7; l++) begin
      check("cl_light_a", lights, l);
      step();
      check("cl_light_b", lights, l);
      step();
    end
    check("cl_light8", lights, 4'd8);
    check("cl_pre_delay", delay_active, 1'b0);
    exp_k = m_lfsr;
    kk = int'(exp_k);
    step();
    check("cl_delay_active", delay_active, 1'b1);
    check("cl_k", delay_k, exp_k);
    for (int i = 1; i <= 2 * kk; i++) begin
      step();
      check("cl_dly_tick", tick, i == 2 * kk);
    end
    check("cl_lights_held", lights, 4'd8);
    step();
    check("cl_lights_out", lights, 4'd0);
    check("cl_tick_total", tick_cnt - base, 9);
    step(); step();
    check("cl_idle", delay_active, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check("cl_no_extra_ticks", tick_cnt - base, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
